// File: rtl/fractal_sync_pkg.sv
// Shared encodings for the fractal barrier register-file controller:
// barrier bit meanings and the per-port response record.
package fractal_sync_pkg;

   localparam logic BIT_IDLE    = 1'b0;
   localparam logic BIT_WAITING = 1'b1;

   // Wide enough for any supported index width; the top truncates to its own.
   localparam int RSP_IDX_W = 16;

   typedef struct packed {
      logic [RSP_IDX_W-1:0] idx;
      logic                 err;
   } rsp_t;

endpackage

// File: rtl/fractal_sync_rr_arb.sv
// Round-robin pair selector for one barrier index: picks the first two
// eligible ports starting at ptr_i and flags ports that come after both.
module fractal_sync_rr_arb
   import fractal_sync_pkg::*;
#(
   parameter int N_PORTS = 2,
   parameter int PTR_W   = 1
) (
   input  logic [N_PORTS-1:0] elig_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [N_PORTS-1:0] first_o,
   output logic [N_PORTS-1:0] second_o,
   output logic [N_PORTS-1:0] blocked_o,
   output logic [PTR_W-1:0]   first_idx_o
);

   // blocked_o[p] ignores elig_i[p] itself, so a port's ready never depends on its own valid.
   always_comb begin
      int cnt;
      int p;
      cnt         = 0;
      first_o     = '0;
      second_o    = '0;
      blocked_o   = '0;
      first_idx_o = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         p = (int'(ptr_i) + k) % N_PORTS;
         blocked_o[p] = (cnt >= 2);
         if (elig_i[p]) begin
            if (cnt == 0) begin
               first_o[p]  = 1'b1;
               first_idx_o = PTR_W'(p);
            end else if (cnt == 1) begin
               second_o[p] = 1'b1;
            end
            cnt = cnt + 1;
         end
      end
   end

endmodule

// File: rtl/fractal_sync_rf_ctrl.sv
// Two-participant barrier controller in front of a 1-bit multi-port register
// file: toggles barrier bits on arrival and returns completion responses.
module fractal_sync_rf_ctrl
   import fractal_sync_pkg::*;
#(
   parameter int N_PORTS   = 2,
   parameter int N_REGS    = 2,
   parameter int IDX_WIDTH = 1
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [N_PORTS-1:0]                  req_valid_i,
   input  logic [N_PORTS-1:0][IDX_WIDTH-1:0]   req_idx_i,
   output logic [N_PORTS-1:0]                  req_ready_o,
   output logic [N_PORTS-1:0]                  rsp_valid_o,
   output logic [N_PORTS-1:0][IDX_WIDTH-1:0]   rsp_idx_o,
   output logic [N_PORTS-1:0]                  rsp_err_o,
   input  logic [N_PORTS-1:0]                  rsp_ready_i,
   output logic [N_PORTS-1:0]                  rf_data_o,
   output logic [N_PORTS-1:0][IDX_WIDTH-1:0]   rf_idx_o,
   output logic [N_PORTS-1:0]                  rf_idx_valid_o,
   input  logic [N_PORTS-1:0]                  rf_data_i,
   output logic [$clog2(N_REGS+1)-1:0]         pending_cnt_o
);

   localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam int CNT_W = $clog2(N_REGS + 1);

   if (2**IDX_WIDTH < N_REGS) begin : g_bad_cfg
      $error("fractal_sync_rf_ctrl: IDX_WIDTH too small for N_REGS");
   end

   logic [N_PORTS-1:0]              rsp_valid_q, rsp_valid_d;
   rsp_t [N_PORTS-1:0]              rsp_q, rsp_d;
   logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic [N_PORTS-1:0]              can_acc, in_range, stall, complete;
   logic [N_REGS-1:0][N_PORTS-1:0]  elig, first, second, blocked;
   logic [N_REGS-1:0][PTR_W-1:0]    first_idx;

   assign can_acc = ~rsp_valid_q | rsp_ready_i;

   always_comb begin
      for (int i = 0; i < N_PORTS; i++) begin
         in_range[i] = int'(req_idx_i[i]) < N_REGS;
      end
      for (int g = 0; g < N_REGS; g++) begin
         for (int i = 0; i < N_PORTS; i++) begin
            elig[g][i] = req_valid_i[i] & can_acc[i] & (req_idx_i[i] == IDX_WIDTH'(g));
         end
      end
   end

   for (genvar g = 0; g < N_REGS; g++) begin : g_arb
      fractal_sync_rr_arb #(.N_PORTS(N_PORTS), .PTR_W(PTR_W)) u_arb (
         .elig_i      (elig[g]),
         .ptr_i       (rr_ptr_q),
         .first_o     (first[g]),
         .second_o    (second[g]),
         .blocked_o   (blocked[g]),
         .first_idx_o (first_idx[g])
      );
   end

   always_comb begin
      int   inc;
      int   dec;
      int   nxt;
      logic b;
      logic nb;
      logic found;
      logic acc;
      logic err;
      inc            = 0;
      dec            = 0;
      found          = 1'b0;
      stall          = '0;
      complete       = '0;
      rf_idx_valid_o = '0;
      rf_data_o      = '0;
      rr_ptr_d       = rr_ptr_q;
      for (int i = 0; i < N_PORTS; i++) begin
         for (int g = 0; g < N_REGS; g++) begin
            if (req_idx_i[i] == IDX_WIDTH'(g) && blocked[g][i]) stall[i] = 1'b1;
         end
      end
      req_ready_o = can_acc & ~stall;
      // Only the first winner writes; a pair of arrivals leaves the bit unchanged.
      for (int g = 0; g < N_REGS; g++) begin
         b  = rf_data_i[first_idx[g]];
         nb = (|second[g]) ? b : ~b;
         if (|first[g]) begin
            rf_idx_valid_o[first_idx[g]] = rst_ni;
            rf_data_o[first_idx[g]]      = nb;
            if (|second[g]) complete = complete | ((b == BIT_WAITING) ? first[g] : second[g]);
            else if (b == BIT_WAITING) complete = complete | first[g];
            if (b == BIT_IDLE && nb == BIT_WAITING) inc = inc + 1;
            if (b == BIT_WAITING && nb == BIT_IDLE) dec = dec + 1;
            if (!found && |(elig[g] & blocked[g])) begin
               found    = 1'b1;
               rr_ptr_d = PTR_W'((int'(first_idx[g]) + 1) % N_PORTS);
            end
         end
      end
      for (int i = 0; i < N_PORTS; i++) begin
         acc            = req_valid_i[i] & req_ready_o[i];
         err            = acc & ~in_range[i];
         rsp_valid_d[i] = complete[i] | err | (rsp_valid_q[i] & ~rsp_ready_i[i]);
         rsp_d[i]       = rsp_q[i];
         if (complete[i] | err) begin
            rsp_d[i].idx = RSP_IDX_W'(req_idx_i[i]);
            rsp_d[i].err = err;
         end
      end
      nxt = int'(cnt_q) + inc - dec;
      if (nxt < 0) nxt = 0;
      if (nxt > N_REGS) nxt = N_REGS;
      cnt_d = CNT_W'(nxt);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_valid_q <= '0;
         rsp_q       <= '0;
         rr_ptr_q    <= '0;
         cnt_q       <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_q       <= rsp_d;
         rr_ptr_q    <= rr_ptr_d;
         cnt_q       <= cnt_d;
      end
   end

   always_comb begin
      for (int i = 0; i < N_PORTS; i++) begin
         rsp_idx_o[i] = IDX_WIDTH'(rsp_q[i].idx);
         rsp_err_o[i] = rsp_q[i].err;
      end
   end

   assign rsp_valid_o   = rsp_valid_q;
   assign rf_idx_o      = req_idx_i;
   assign pending_cnt_o = cnt_q;

endmodule

// File: tb/tb_fractal_sync_rf_ctrl.sv
// Directed bench for fractal_sync_rf_ctrl with a behavioural barrier RF and a
// per-port response scoreboard.
module tb_fractal_sync_rf_ctrl;

   localparam int NP = 3;
   localparam int NR = 3;
   localparam int IW = 2;

   logic                   clk_i;
   logic                   rst_ni;
   logic [NP-1:0]          req_valid_i;
   logic [NP-1:0][IW-1:0]  req_idx_i;
   logic [NP-1:0]          req_ready_o;
   logic [NP-1:0]          rsp_valid_o;
   logic [NP-1:0][IW-1:0]  rsp_idx_o;
   logic [NP-1:0]          rsp_err_o;
   logic [NP-1:0]          rsp_ready_i;
   logic [NP-1:0]          rf_data_o;
   logic [NP-1:0][IW-1:0]  rf_idx_o;
   logic [NP-1:0]          rf_idx_valid_o;
   logic [NP-1:0]          rf_data_i;
   logic [1:0]             pending_cnt_o;

   logic [NR-1:0]          rf;
   logic [IW:0]            exp_q [NP][$];
   int                     checks;
   int                     errors;

   fractal_sync_rf_ctrl #(.N_PORTS(NP), .N_REGS(NR), .IDX_WIDTH(IW)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .req_valid_i    (req_valid_i),
      .req_idx_i      (req_idx_i),
      .req_ready_o    (req_ready_o),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_idx_o      (rsp_idx_o),
      .rsp_err_o      (rsp_err_o),
      .rsp_ready_i    (rsp_ready_i),
      .rf_data_o      (rf_data_o),
      .rf_idx_o       (rf_idx_o),
      .rf_idx_valid_o (rf_idx_valid_o),
      .rf_data_i      (rf_data_i),
      .pending_cnt_o  (pending_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Behavioural barrier RF, cleared together with the controller.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rf <= '0;
      else begin
         for (int p = 0; p < NP; p++) begin
            if (rf_idx_valid_o[p] && int'(rf_idx_o[p]) < NR) rf[rf_idx_o[p]] <= rf_data_o[p];
         end
      end
   end

   always_comb begin
      for (int p = 0; p < NP; p++) begin
         rf_data_i[p] = (int'(req_idx_i[p]) < NR) ? rf[req_idx_i[p]] : 1'b0;
      end
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic apply_stimulus(input logic [NP-1:0] v, input int i0, input int i1, input int i2);
      req_valid_i  = v;
      req_idx_i[0] = IW'(i0);
      req_idx_i[1] = IW'(i1);
      req_idx_i[2] = IW'(i2);
   endtask

   task automatic expect_rsp(input int p, input int idx, input logic err);
      exp_q[p].push_back({IW'(idx), err});
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Scoreboard: every response handshake must match the oldest expectation.
   always @(negedge clk_i) begin
      logic [IW:0] e;
      for (int p = 0; p < NP; p++) begin
         if (rst_ni && rsp_valid_o[p] && rsp_ready_i[p]) begin
            if (exp_q[p].size() == 0) begin
               checks++;
               errors++;
               $error("FAIL rsp_unexpected port=%0d observed idx=%0d err=%0d expected none",
                      p, rsp_idx_o[p], rsp_err_o[p]);
            end else begin
               e = exp_q[p].pop_front();
               check_output($sformatf("rsp_port%0d", p), {29'd0, rsp_idx_o[p], rsp_err_o[p]}, {29'd0, e});
            end
         end
      end
   end

   initial begin
      checks      = 0;
      errors      = 0;
      rst_ni      = 1'b0;
      rsp_ready_i = '1;
      apply_stimulus(3'b001, 0, 0, 0);
      #3;
      check_output("reset_rsp_valid", rsp_valid_o, 0);
      check_output("reset_pending", pending_cnt_o, 0);
      check_output("reset_rf_we", rf_idx_valid_o, 0);
      check_output("reset_rsp_idx", rsp_idx_o, 0);
      tick();
      rst_ni = 1'b1;
      apply_stimulus(3'b000, 0, 0, 0);
      tick();

      // Two separated arrivals on idx1 complete on the second port.
      apply_stimulus(3'b001, 1, 0, 0);
      @(negedge clk_i);
      check_output("s1_we_first", rf_idx_valid_o, 3'b001);
      check_output("s1_data_first", rf_data_o[0], 1);
      tick();
      apply_stimulus(3'b000, 0, 0, 0);
      check_output("s1_pending_1", pending_cnt_o, 1);
      check_output("s1_no_rsp", rsp_valid_o, 0);
      tick();
      tick();
      apply_stimulus(3'b010, 0, 1, 0);
      expect_rsp(1, 1, 1'b0);
      @(negedge clk_i);
      check_output("s1_we_second", rf_idx_valid_o, 3'b010);
      tick();
      apply_stimulus(3'b000, 0, 0, 0);
      check_output("s1_rsp_valid", rsp_valid_o, 3'b010);
      check_output("s1_pending_0", pending_cnt_o, 0);
      tick();

      // Simultaneous pair on an idle bit.
      apply_stimulus(3'b011, 0, 0, 0);
      expect_rsp(1, 0, 1'b0);
      @(negedge clk_i);
      check_output("s2_single_we", rf_idx_valid_o, 3'b001);
      check_output("s2_data", rf_data_o, 0);
      tick();
      apply_stimulus(3'b000, 0, 0, 0);
      check_output("s2_rsp_port1_only", rsp_valid_o, 3'b010);
      check_output("s2_bit0", rf[0], 0);
      check_output("s2_pending", pending_cnt_o, 0);
      tick();

      // Three arrivals on one index: third port stalls then goes alone.
      apply_stimulus(3'b111, 0, 0, 0);
      expect_rsp(1, 0, 1'b0);
      @(negedge clk_i);
      check_output("s3_ready", req_ready_o, 3'b011);
      check_output("s3_we", rf_idx_valid_o, 3'b001);
      tick();
      apply_stimulus(3'b100, 0, 0, 0);
      @(negedge clk_i);
      check_output("s3_port2_ready", req_ready_o[2], 1);
      check_output("s3_port2_we", rf_idx_valid_o, 3'b100);
      check_output("s3_port2_data", rf_data_o[2], 1);
      tick();
      apply_stimulus(3'b001, 0, 0, 0);
      expect_rsp(0, 0, 1'b0);
      check_output("s3_bit0_set", rf[0], 1);
      check_output("s3_pending", pending_cnt_o, 1);
      tick();
      apply_stimulus(3'b000, 0, 0, 0);
      check_output("s3_pending_clear", pending_cnt_o, 0);
      tick();

      // Out-of-range index.
      apply_stimulus(3'b001, 3, 0, 0);
      expect_rsp(0, 3, 1'b1);
      @(negedge clk_i);
      check_output("s4_no_we", rf_idx_valid_o, 0);
      tick();
      apply_stimulus(3'b000, 0, 0, 0);
      check_output("s4_err", rsp_err_o[0], 1);
      check_output("s4_rf", rf, 0);
      check_output("s4_pending", pending_cnt_o, 0);
      tick();

      // Held response blocks the port, then drains back-to-back.
      apply_stimulus(3'b010, 0, 1, 0);
      tick();
      rsp_ready_i[0] = 1'b0;
      apply_stimulus(3'b001, 1, 0, 0);
      expect_rsp(0, 1, 1'b0);
      tick();
      apply_stimulus(3'b001, 2, 0, 0);
      @(negedge clk_i);
      check_output("s5_ready_low", req_ready_o[0], 0);
      check_output("s5_no_we", rf_idx_valid_o, 0);
      tick();
      check_output("s5_rsp_held", {rsp_valid_o[0], rsp_idx_o[0]}, 3'b101);
      check_output("s5_bit2_clear", rf[2], 0);
      apply_stimulus(3'b010, 0, 2, 0);
      tick();
      check_output("s5_pending", pending_cnt_o, 1);
      rsp_ready_i[0] = 1'b1;
      apply_stimulus(3'b001, 2, 0, 0);
      expect_rsp(0, 2, 1'b0);
      @(negedge clk_i);
      check_output("s5_ready_high", req_ready_o[0], 1);
      tick();
      apply_stimulus(3'b000, 0, 0, 0);
      check_output("s5_b2b", {rsp_valid_o[0], rsp_idx_o[0]}, 3'b110);
      check_output("s5_pending_0", pending_cnt_o, 0);
      tick();
      tick();

      // Reset with a waiting arrival discards it.
      apply_stimulus(3'b001, 1, 0, 0);
      tick();
      apply_stimulus(3'b000, 0, 0, 0);
      check_output("s6_pending_pre", pending_cnt_o, 1);
      tick();
      rst_ni = 1'b0;
      apply_stimulus(3'b010, 0, 1, 0);
      #1;
      check_output("s6_rst_we", rf_idx_valid_o, 0);
      check_output("s6_rst_pending", pending_cnt_o, 0);
      check_output("s6_rst_rsp", rsp_valid_o, 0);
      tick();
      rst_ni = 1'b1;
      apply_stimulus(3'b000, 0, 0, 0);
      tick();
      apply_stimulus(3'b010, 0, 1, 0);
      tick();
      apply_stimulus(3'b000, 0, 0, 0);
      check_output("s6_no_rsp", rsp_valid_o, 0);
      check_output("s6_pending", pending_cnt_o, 1);
      check_output("s6_bit1", rf[1], 1);
      apply_stimulus(3'b111, 0, 0, 0);
      expect_rsp(1, 0, 1'b0);
      @(negedge clk_i);
      check_output("s6_rr_reset_ready", req_ready_o, 3'b011);
      tick();
      apply_stimulus(3'b000, 0, 0, 0);
      tick();
      tick();

      for (int p = 0; p < NP; p++) begin
         check_output($sformatf("drained_port%0d", p), exp_q[p].size(), 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fractal_sync_rf_ctrl.md
FRACTAL_SYNC_RF_CTRL -- requirements
Module: fractal_sync_rf_ctrl

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, meaning number of arrival requesters and of multi-port RF ports driven.
REQ-002 SHALL have parameter N_REGS, default 2, meaning number of barrier bits in the controlled register file.
REQ-003 SHALL have parameter IDX_WIDTH, default 1, meaning barrier index width; elaboration SHALL fail if 2**IDX_WIDTH < N_REGS.
REQ-004 clk_i  input  1  single clock, rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 req_valid_i[N_PORTS]  input  1  arrival request valid, per port.
REQ-007 req_idx_i[N_PORTS]  input  IDX_WIDTH  barrier index of the arrival.
REQ-008 req_ready_o[N_PORTS]  output  1  arrival accepted when valid&ready.
REQ-009 rsp_valid_o[N_PORTS]  output  1  barrier-complete response pending.
REQ-010 rsp_idx_o[N_PORTS]  output  IDX_WIDTH  index of the completed barrier.
REQ-011 rsp_err_o[N_PORTS]  output  1  response flags an out-of-range index.
REQ-012 rsp_ready_i[N_PORTS]  input  1  response consumed when valid&ready.
REQ-013 rf_data_o[N_PORTS], rf_idx_o[N_PORTS] (IDX_WIDTH), rf_idx_valid_o[N_PORTS]  output  RF write data, index and write enable.
REQ-014 rf_data_i[N_PORTS]  input  1  RF read data at rf_idx_o (combinational, current state).
REQ-015 pending_cnt_o  output  $clog2(N_REGS+1)  number of barrier bits currently set.

Function
REQ-016 Each barrier has two participants; bit=0 idle, bit=1 one arrival waiting; an arrival toggles the bit, and a 1->0 toggle completes the barrier.
REQ-017 req_ready_o[i] SHALL be (!rsp_valid_o[i] | rsp_ready_i[i]) & !stall[i]; it SHALL NOT depend on req_valid_i[i].
REQ-018 rf_idx_o[i] SHALL equal req_idx_i[i] every cycle; lookup and write complete in the accept cycle; the new bit is visible to any port on the next cycle.
REQ-019 Per index per cycle at most two arrivals SHALL be accepted; the winners are the first two eligible ports in round-robin order from rr_ptr; the remaining ports get stall[i]=1.
REQ-020 One accepted arrival at bit b: new bit = !b; completes iff b=1.
REQ-021 Two accepted arrivals at bit b: bit unchanged; the completer is the second winner if b=0, the first winner if b=1.
REQ-022 Exactly one winner per index (the first) SHALL drive rf_idx_valid_o=1 with rf_data_o = new bit; every other port SHALL drive rf_idx_valid_o=0 and rf_data_o=0.
REQ-023 Completion on port i SHALL load rsp_valid_o[i]=1, rsp_idx_o[i]=index and rsp_err_o[i]=0 on the next edge (latency 1); the response SHALL hold until rsp_ready_i[i].
REQ-024 An accepted arrival with index >= N_REGS SHALL leave the RF untouched and load a response with rsp_err_o=1; it is not counted in REQ-019.
REQ-025 Simultaneous drain and accept on one port SHALL allow a back-to-back response; rsp_valid_o stays 1.
REQ-026 rr_ptr SHALL advance to one past the first winner whenever any stall occurs; otherwise it holds.
REQ-027 pending_cnt_o SHALL update each cycle by +(#indices going 0->1) - (#indices going 1->0); it SHALL never wrap.

Reset
REQ-028 On reset: rsp_valid_o=0, rsp_idx_o=0, rsp_err_o=0, rr_ptr=0, pending_cnt_o=0; all rf_idx_valid_o SHALL be 0 while rst_ni=0.
REQ-029 Reset mid-operation SHALL discard waiting arrivals; the RF, reset with it, SHALL agree with pending_cnt_o=0.

Structure
REQ-030 A shared package fractal_sync_pkg SHALL hold the barrier-bit encoding constants (IDLE=0, WAITING=1) and the response struct (idx, err).
REQ-031 One sub-module, fractal_sync_rr_arb (round-robin pair selector per index), SHALL be instantiated once per index group; all other logic is inline.

Verification
REQ-032 Port0 arrives idx1, then port1 arrives idx1 three cycles later -> no response after the first; rsp_valid_o[1]=1 with idx=1 one cycle after the second; pending_cnt 0->1->0.
REQ-033 Ports 0 and 1 arrive idx0 in the same cycle with bit=0 -> exactly one rf_idx_valid_o; bit stays 0; response on port1 only; pending_cnt stays 0.
REQ-034 N_PORTS=3, all three arrive idx0 same cycle, rr_ptr=0 -> ports 0 and 1 accepted, port2 stalled; the next cycle port2 is accepted and the bit becomes 1.
REQ-035 N_REGS=3, IDX_WIDTH=2, arrival idx3 -> rsp_err_o=1, RF unchanged, pending_cnt unchanged.
REQ-036 rsp_ready_i[0]=0 with a response held -> req_ready_o[0]=0; raise rsp_ready_i with a new completing arrival -> back-to-back responses.
REQ-037 Assert rst_ni low with bit idx1 waiting -> all outputs reset; a later single arrival on idx1 yields no response.
